station_dock_ctrl: RTL and testbench

- Sequences rover drive speed around station docking, using the four IR distance sensors DIS[3:0]; pair {1,0} covers side A, pair {3,2} covers side B.
- Sits between the raw sensor pins and the motor PWM speed selector.
- Debounces each sensor, slows the rover on first contact, stops it and pulses an arrival on full pair contact, and dwells at the station.
- Departs with a sensor lockout so the same station is not re-detected.

---
 rtl/station_dock_pkg.sv | 19 +
 rtl/station_dock_ctrl_debounce.sv | 52 +++++
 rtl/station_dock_ctrl.sv | 118 +++++++++++
 tb/tb_station_dock_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/station_dock_pkg.sv
// Shared constants for the station docking controller: FSM state encodings,
// speed selector codes and a small elaboration-time helper.
package station_dock_pkg;

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] CRUISE = 3'b001;
    localparam logic [2:0] SLOW   = 3'b010;
    localparam logic [2:0] DOCKED = 3'b011;
    localparam logic [2:0] DEPART = 3'b100;

    localparam logic [1:0] SPD_STOP = 2'b00;
    localparam logic [1:0] SPD_SLOW = 2'b01;
    localparam logic [1:0] SPD_FULL = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/station_dock_ctrl_debounce.sv
// One IR sensor bit: two-flop synchroniser followed by a run-length debouncer
// that flips its output only after DEBOUNCE_CYC consecutive disagreeing cycles.
module dis_debounce
    import station_dock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = max_int($clog2(DEBOUNCE_CYC), 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any cycle of agreement restarts the run, so short glitches never flip the output.
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/station_dock_ctrl.sv
// Rover docking sequencer: debounces the four IR sensors, slows on first contact,
// stops and counts arrivals on full pair contact, dwells, then departs with a lockout.
module station_dock_ctrl
    import station_dock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100000,
    parameter int DWELL_CYC    = 200000000,
    parameter int LOCKOUT_CYC  = 50000000,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [3:0]       DIS,
    input  logic             resume,
    output logic [1:0]       speed_cmd,
    output logic [1:0]       dock_side,
    output logic             arrived,
    output logic [CNT_W-1:0] station_cnt,
    output logic [2:0]       state_dbg
);

    localparam int TW = $clog2(max_int(max_int(DWELL_CYC, LOCKOUT_CYC), 2));

    logic [3:0] deb;
    logic       d_a, d_b, any_contact, pair;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        dis_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .din  (DIS[i]),
            .dout (deb[i])
        );
    end

    assign d_a         = &deb[1:0];
    assign d_b         = &deb[3:2];
    assign any_contact = |deb;
    assign pair        = d_a | d_b;

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [1:0]       speed_q, speed_d;
    logic [1:0]       dock_side_q, dock_side_d;
    logic             arrived_q, arrived_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The single timer serves both the DOCKED dwell and the DEPART lockout;
    // it is held at zero in every other state so each phase starts from zero.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        dock_side_d = dock_side_q;
        cnt_d       = cnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = CRUISE;
                CRUISE: begin
                    if (pair)             state_d = DOCKED;
                    else if (any_contact) state_d = SLOW;
                end
                SLOW: begin
                    if (pair)              state_d = DOCKED;
                    else if (!any_contact) state_d = CRUISE;
                end
                DOCKED: begin
                    if (resume || timer_q == TW'(DWELL_CYC - 1)) state_d = DEPART;
                    else                                         timer_d = timer_q + TW'(1);
                end
                DEPART: begin
                    if (timer_q == TW'(LOCKOUT_CYC - 1)) state_d = CRUISE;
                    else                                 timer_d = timer_q + TW'(1);
                end
                default: state_d = IDLE;
            endcase
        end

        arrived_d = (state_d == DOCKED) && (state_q != DOCKED);
        if (arrived_d) begin
            dock_side_d = {d_b, d_a};
            cnt_d       = cnt_q + CNT_W'(1);
        end

        case (state_d)
            CRUISE, DEPART: speed_d = SPD_FULL;
            SLOW:           speed_d = SPD_SLOW;
            default:        speed_d = SPD_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            speed_q     <= SPD_STOP;
            dock_side_q <= 2'b00;
            arrived_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            speed_q     <= speed_d;
            dock_side_q <= dock_side_d;
            arrived_q   <= arrived_d;
            cnt_q       <= cnt_d;
        end
    end

    assign speed_cmd   = speed_q;
    assign dock_side   = dock_side_q;
    assign arrived     = arrived_q;
    assign station_cnt = cnt_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_station_dock_ctrl.sv
// Directed bench for station_dock_ctrl with short timing parameters; every check
// compares the packed {state, speed, dock_side, arrived, station_cnt} tuple.
module tb_station_dock_ctrl;

    localparam logic [2:0] T_IDLE   = 3'b000;
    localparam logic [2:0] T_CRUISE = 3'b001;
    localparam logic [2:0] T_SLOW   = 3'b010;
    localparam logic [2:0] T_DOCKED = 3'b011;
    localparam logic [2:0] T_DEPART = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] dis;
    logic       resume;
    logic [1:0] speed_cmd;
    logic [1:0] dock_side;
    logic       arrived;
    logic [3:0] station_cnt;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    logic [11:0] obs;
    assign obs = {state_dbg, speed_cmd, dock_side, arrived, station_cnt};

    station_dock_ctrl #(
        .DEBOUNCE_CYC (4),
        .DWELL_CYC    (20),
        .LOCKOUT_CYC  (10),
        .CNT_W        (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .DIS         (dis),
        .resume      (resume),
        .speed_cmd   (speed_cmd),
        .dock_side   (dock_side),
        .arrived     (arrived),
        .station_cnt (station_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] ev(input logic [2:0] st, input logic [1:0] spd,
                                       input logic [1:0] side, input logic arr, input int cnt);
        logic [3:0] c;
        c = 4'(cnt);
        return {st, spd, side, arr, c};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst = 1'b1; enable = 1'b0; dis = 4'b0000; resume = 1'b0;
        tick(3);
        e = ev(T_IDLE, 2'b00, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL reset_hold: got %h expected %h", obs, e); end
        rst = 1'b0;
        tick(1);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL idle_no_enable: got %h expected %h", obs, e); end
        enable = 1'b1;
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL cruise_start: got %h expected %h", obs, e); end
    endtask

    task automatic test_side_a_dock();
        logic [11:0] e;
        dis = 4'b0001;
        tick(6);
        e = ev(T_CRUISE, 2'b10, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_still_cruise: got %h expected %h", obs, e); end
        dis = 4'b0011;
        tick(1);
        e = ev(T_SLOW, 2'b01, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_slow: got %h expected %h", obs, e); end
        tick(5);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_slow_hold: got %h expected %h", obs, e); end
        tick(1);
        exp_cnt = 1;
        e = ev(T_DOCKED, 2'b00, 2'b01, 1'b1, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_arrive: got %h expected %h", obs, e); end
        dis = 4'b0000;
        tick(1);
        e = ev(T_DOCKED, 2'b00, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_pulse_end: got %h expected %h", obs, e); end
        tick(18);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_dwell_last: got %h expected %h", obs, e); end
        tick(1);
        e = ev(T_DEPART, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_depart: got %h expected %h", obs, e); end
        tick(9);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_lockout_last: got %h expected %h", obs, e); end
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL a_recruise: got %h expected %h", obs, e); end
    endtask

    task automatic test_glitch_and_false_contact();
        logic [11:0] e;
        dis = 4'b0100;
        tick(3);
        dis = 4'b0000;
        tick(10);
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL glitch_ignored: got %h expected %h", obs, e); end
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL resume_in_cruise: got %h expected %h", obs, e); end
        dis = 4'b0100;
        tick(6);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL b_pre_slow: got %h expected %h", obs, e); end
        dis = 4'b0000;
        tick(1);
        e = ev(T_SLOW, 2'b01, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL false_slow: got %h expected %h", obs, e); end
        tick(5);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL false_slow_hold: got %h expected %h", obs, e); end
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL false_back_cruise: got %h expected %h", obs, e); end
    endtask

    task automatic test_both_sides_resume();
        logic [11:0] e;
        dis = 4'b1111;
        tick(6);
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL both_pre: got %h expected %h", obs, e); end
        tick(1);
        exp_cnt = exp_cnt + 1;
        e = ev(T_DOCKED, 2'b00, 2'b11, 1'b1, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL both_direct_dock: got %h expected %h", obs, e); end
        dis = 4'b0000;
        tick(1);
        e = ev(T_DOCKED, 2'b00, 2'b11, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL both_single_pulse: got %h expected %h", obs, e); end
        tick(2);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        e = ev(T_DEPART, 2'b10, 2'b11, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL resume_depart: got %h expected %h", obs, e); end
        tick(10);
        e = ev(T_CRUISE, 2'b10, 2'b11, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL resume_recruise: got %h expected %h", obs, e); end
    endtask

    task automatic test_resume_at_expiry();
        logic [11:0] e;
        dis = 4'b0011;
        tick(6);
        dis = 4'b0000;
        tick(1);
        exp_cnt = exp_cnt + 1;
        e = ev(T_DOCKED, 2'b00, 2'b01, 1'b1, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL exp_arrive: got %h expected %h", obs, e); end
        tick(19);
        resume = 1'b1;
        tick(1);
        resume = 1'b0;
        e = ev(T_DEPART, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL exp_depart: got %h expected %h", obs, e); end
        tick(9);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL exp_lockout_full: got %h expected %h", obs, e); end
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL exp_recruise: got %h expected %h", obs, e); end
    endtask

    task automatic test_back_to_back_wrap();
        logic [11:0] e;
        for (int i = 0; i < 13; i++) begin
            dis = 4'b0011;
            tick(6);
            dis = 4'b0000;
            tick(1);
            exp_cnt = (exp_cnt + 1) % 16;
            e = ev(T_DOCKED, 2'b00, 2'b01, 1'b1, exp_cnt);
            n_vec++;
            if (obs !== e) begin n_bad++; $display("[TB] FAIL wrap_arrive_%0d: got %h expected %h", i, obs, e); end
            resume = 1'b1;
            tick(1);
            resume = 1'b0;
            tick(10);
            e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, exp_cnt);
            n_vec++;
            if (obs !== e) begin n_bad++; $display("[TB] FAIL wrap_cruise_%0d: got %h expected %h", i, obs, e); end
        end
        e = ev(T_CRUISE, 2'b10, 2'b01, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL wrap_zero: got %h expected %h", obs, e); end
    endtask

    task automatic test_enable_drop();
        logic [11:0] e;
        dis = 4'b1100;
        tick(6);
        dis = 4'b0000;
        tick(1);
        exp_cnt = (exp_cnt + 1) % 16;
        e = ev(T_DOCKED, 2'b00, 2'b10, 1'b1, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL side_b_arrive: got %h expected %h", obs, e); end
        enable = 1'b0;
        tick(1);
        e = ev(T_IDLE, 2'b00, 2'b10, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL disable_idle: got %h expected %h", obs, e); end
        tick(10);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL disable_hold: got %h expected %h", obs, e); end
        enable = 1'b1;
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b10, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL reenable_cruise: got %h expected %h", obs, e); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        dis = 4'b0100;
        tick(7);
        e = ev(T_SLOW, 2'b01, 2'b10, 1'b0, exp_cnt);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL pre_reset_slow: got %h expected %h", obs, e); end
        rst = 1'b1;
        tick(1);
        e = ev(T_IDLE, 2'b00, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL mid_reset: got %h expected %h", obs, e); end
        dis = 4'b0000;
        rst = 1'b0;
        tick(1);
        e = ev(T_CRUISE, 2'b10, 2'b00, 1'b0, 0);
        n_vec++;
        if (obs !== e) begin n_bad++; $display("[TB] FAIL post_reset_cruise: got %h expected %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_side_a_dock();
        test_glitch_and_false_contact();
        test_both_sides_resume();
        test_resume_at_expiry();
        test_back_to_back_wrap();
        test_enable_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
